// File: rtl/mux_21_4.sv
// -----------------------------------------------------------------------------
// mux_21_4
//   Word-wide 2-to-1 multiplexer used to steer one of two operand sources
//   into downstream logic. Besides the combinational result it provides a
//   registered copy and reports select activity (edge pulse + wrapping count).
//
// Ports
//   i_clk       : system clock, all state updates on the rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_s         : select, 0 -> i_w0, 1 -> i_w1
//   i_w0, i_w1  : data words
//   o_f         : combinational mux result (not touched by reset)
//   o_f_q       : mux result registered on the rising edge
//   o_sel_chg   : one-cycle pulse when the sampled select differs from the
//                 previous sample
//   o_chg_cnt   : count of detected select edges, wraps silently
// -----------------------------------------------------------------------------
module mux_21_4 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_s,
    input  logic [WIDTH-1:0] i_w0,
    input  logic [WIDTH-1:0] i_w1,
    output logic [WIDTH-1:0] o_f,
    output logic [WIDTH-1:0] o_f_q,
    output logic             o_sel_chg,
    output logic [CNT_W-1:0] o_chg_cnt
);

    logic [WIDTH-1:0] f_q,   f_d;
    logic             s_q,   s_d;
    logic             chg_q, chg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Same-delta result; no state involved so reset has no effect on it.
    assign o_f = i_s ? i_w1 : i_w0;

    always_comb begin
        f_d   = o_f;
        s_d   = i_s;
        // s_q resets to 0, so a select held at 1 across reset release
        // registers as an edge on the first clock.
        chg_d = (i_s != s_q);
        cnt_d = cnt_q;
        if (chg_d) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            f_q   <= '0;
            s_q   <= 1'b0;
            chg_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            f_q   <= f_d;
            s_q   <= s_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_f_q     = f_q;
    assign o_sel_chg = chg_q;
    assign o_chg_cnt = cnt_q;

endmodule

// File: tb/tb_mux_21_4.sv
module tb_mux_21_4;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int EXP_W = WIDTH + 1 + CNT_W;

  // ---------------- clock / reset ----------------
  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_s = 1'b0;
  logic [WIDTH-1:0] i_w0 = '0;
  logic [WIDTH-1:0] i_w1 = '0;
  logic [WIDTH-1:0] o_f;
  logic [WIDTH-1:0] o_f_q;
  logic             o_sel_chg;
  logic [CNT_W-1:0] o_chg_cnt;

  always #5 i_clk = ~i_clk;

  mux_21_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_s       (i_s),
    .i_w0      (i_w0),
    .i_w1      (i_w1),
    .o_f       (o_f),
    .o_f_q     (o_f_q),
    .o_sel_chg (o_sel_chg),
    .o_chg_cnt (o_chg_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;

  // reference state of the select tracker
  logic             m_s_q = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] mux_ref(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return s ? b : a;
  endfunction

  // ---------------- driver tasks ----------------
  // Apply one cycle of stimulus at the falling edge, check the combinational
  // output right away, push the registered expectation and check it after
  // the next rising edge. rel releases reset on this same falling edge;
  // glitch pulses the select to the opposite value and back before the edge.
  task automatic drive_cycle(input logic s, input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                             input logic rel, input logic glitch);
    logic             chg;
    logic [EXP_W-1:0] e;
    @(negedge i_clk);
    if (rel) i_rst_n = 1'b1;
    i_w0 = w0;
    i_w1 = w1;
    if (glitch) begin
      i_s = ~s;
      #1 check("o_f_glitch", o_f, mux_ref(~s, w0, w1));
      i_s = s;
    end else begin
      i_s = s;
    end
    #1 check("o_f", o_f, mux_ref(s, w0, w1));
    chg   = (s != m_s_q);
    m_cnt = m_cnt + (chg ? 1 : 0);
    m_s_q = s;
    exp_q.push_back({mux_ref(s, w0, w1), chg, m_cnt});
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("o_f_q",     o_f_q,     e[EXP_W-1 -: WIDTH]);
      check("o_sel_chg", o_sel_chg, e[CNT_W]);
      check("o_chg_cnt", o_chg_cnt, e[CNT_W-1:0]);
    end
  endtask

  // Assert reset between clock edges and check the registers clear at once
  // while the combinational output keeps following the inputs.
  task automatic async_reset(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_f_q",   o_f_q,     32'd0);
    check("rst_chg",   o_sel_chg, 32'd0);
    check("rst_cnt",   o_chg_cnt, 32'd0);
    i_w0 = w0;
    i_w1 = w1;
    i_s  = ~i_s;
    #1 check("rst_o_f", o_f, mux_ref(i_s, w0, w1));
    m_s_q = 1'b0;
    m_cnt = '0;
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  logic s_cur;

  initial begin
    // reset state
    #3;
    check("init_f_q", o_f_q,     32'd0);
    check("init_chg", o_sel_chg, 32'd0);
    check("init_cnt", o_chg_cnt, 32'd0);

    // combinational select, no clock edge involved
    @(negedge i_clk);
    i_w0 = 4'b0101; i_w1 = 4'b1110; i_s = 1'b0;
    #1 check("comb_s0", o_f, 32'h5);
    i_s = 1'b1;
    #1 check("comb_s1", o_f, 32'he);

    // release reset with select low: no edge
    drive_cycle(1'b0, 4'b0101, 4'b1110, 1'b1, 1'b0);

    // periodic toggle every 100 ns (10 cycles)
    s_cur = 1'b0;
    for (int t = 0; t < 6; t++) begin
      s_cur = ~s_cur;
      for (int c = 0; c < 10; c++) drive_cycle(s_cur, 4'b0101, 4'b1110, 1'b0, 1'b0);
    end

    // data change with select fixed at 1
    drive_cycle(1'b1, 4'($urandom_range(0, 15)), 4'b1110, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) drive_cycle(1'b1, 4'($urandom_range(0, 15)), 4'b0011, 1'b0, 1'b0);

    // double toggle between edges must not register an edge
    drive_cycle(1'b1, 4'b1010, 4'b0110, 1'b0, 1'b1);
    drive_cycle(1'b0, 4'b1010, 4'b0110, 1'b0, 1'b1);

    // random mix
    for (int c = 0; c < 40; c++)
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'b0, 1'b0);

    // bring the count to exactly 5 from a clean reset, then reset mid-operation
    async_reset(4'b0101, 4'b1110);
    drive_cycle(1'b0, 4'b0101, 4'b1110, 1'b1, 1'b0);
    s_cur = 1'b0;
    for (int t = 0; t < 5; t++) begin
      s_cur = ~s_cur;
      drive_cycle(s_cur, 4'b0101, 4'b1110, 1'b0, 1'b0);
      drive_cycle(s_cur, 4'b0101, 4'b1110, 1'b0, 1'b0);
    end
    check("cnt_is_5", o_chg_cnt, 32'd5);
    async_reset(4'b1001, 4'b0111);
    // release with select high: first edge counts
    drive_cycle(1'b1, 4'b0101, 4'b1110, 1'b1, 1'b0);
    check("post_rst_chg", o_sel_chg, 32'd1);
    check("post_rst_cnt", o_chg_cnt, 32'd1);

    // counter wrap: 256 toggles spaced 2 clocks apart from a zero count
    async_reset(4'b0101, 4'b1110);
    drive_cycle(1'b0, 4'b0101, 4'b1110, 1'b1, 1'b0);
    s_cur = 1'b0;
    for (int t = 0; t < 256; t++) begin
      s_cur = ~s_cur;
      drive_cycle(s_cur, 4'b0101, 4'b1110, 1'b0, 1'b0);
      if (t == 254) check("cnt_255", o_chg_cnt, 32'd255);
      drive_cycle(s_cur, 4'b0101, 4'b1110, 1'b0, 1'b0);
    end
    check("cnt_wrap", o_chg_cnt, 32'd0);

    check("sb_drained", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop in case anything stalls
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
